// File: rtl/count_capture_pkg.sv
// Shared defaults and helpers for the timestamp capture stage.
package count_capture_pkg;

    localparam int CC_WIDTH = 8;
    localparam int CC_DEPTH = 4;
    localparam int CC_SYNC  = 2;

    function automatic int lvl_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through FIFO with registered head outputs.
module ts_fifo
    import count_capture_pkg::*;
#(
    parameter int DW    = CC_WIDTH + 1,
    parameter int DEPTH = CC_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       ready,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       valid,
    output logic [lvl_bits(DEPTH)-1:0] level,
    output logic                       full,
    output logic                       wr_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr, rd;
    logic [AW:0]   wr_nxt, rd_nxt, lvl_nxt;
    logic [DW-1:0] head_nxt;
    logic          pop;

    assign level   = wr - rd;
    assign full    = level == (AW+1)'(DEPTH);
    assign pop     = valid & ready;
    assign wr_ok   = push & (~full | pop);
    assign wr_nxt  = wr + (AW+1)'(wr_ok);
    assign rd_nxt  = rd + (AW+1)'(pop);
    assign lvl_nxt = wr_nxt - rd_nxt;

    // Head register is preloaded with whatever sits at the next read slot;
    // an entry written this cycle bypasses the memory.
    always_comb begin
        head_nxt = dout;
        if (lvl_nxt != '0) begin
            if (wr_ok && rd_nxt == wr)
                head_nxt = din;
            else
                head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr    <= '0;
            rd    <= '0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            wr    <= wr_nxt;
            rd    <= rd_nxt;
            dout  <= head_nxt;
            valid <= lvl_nxt != '0;
        end
    end

endmodule

// File: rtl/count_capture.sv
// Event-triggered counter timestamp capture with overflow and wrap flags.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH       = CC_WIDTH,
    parameter int DEPTH       = CC_DEPTH,
    parameter int SYNC_STAGES = CC_SYNC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       event_in,
    output logic [WIDTH-1:0]           ts_out,
    output logic                       ts_wrap,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [lvl_bits(DEPTH)-1:0] level,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   evt_q;
    logic                   push;
    logic                   wr_ok;
    logic                   full;
    logic                   dec;
    logic                   wrap_pend;
    logic [WIDTH-1:0]       count_prev;

    assign push = sync[SYNC_STAGES-1] & ~evt_q;
    assign dec  = count_in < count_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync       <= '0;
            evt_q      <= 1'b0;
            count_prev <= '0;
            wrap_pend  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], event_in};
            evt_q      <= sync[SYNC_STAGES-1];
            count_prev <= count_in;
            // a decrease in the push cycle is already folded into the entry
            if (wr_ok)
                wrap_pend <= 1'b0;
            else if (dec)
                wrap_pend <= 1'b1;
            if (push && !wr_ok)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    ts_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .ready (ts_ready),
        .din   ({wrap_pend | dec, count_in}),
        .dout  ({ts_wrap, ts_out}),
        .valid (ts_valid),
        .level (level),
        .full  (full),
        .wr_ok (wr_ok)
    );

    logic unused_full;
    assign unused_full = full;

endmodule
